// File: rtl/pixel_readout.sv
// ----------------------------------------------------------------------------
// pixel_readout
//
// Readout stage behind the camera controller. Each rising edge of the ADC
// strobe, while idle, selects a row from the active-low row enables, waits
// ADC_LATENCY cycles for the column converters, samples both column results
// and queues them as two FIFO entries (column 0 first). The FIFO head is
// presented show-ahead on a valid/ready stream. Completed frames (row 1
// pairs) are counted, and bad row selects and dropped pairs are flagged.
//
// Optional feature macro: PIXEL_READOUT_TAG_EN
//   defined     : Data_out is W+2 bits, {row, col, pixel}
//   not defined : Data_out is W bits, pixel only
//
// Parameters:
//   W            ADC sample width
//   DEPTH        FIFO depth in pixel entries (power of two, >= 2)
//   ADC_LATENCY  cycles from registered ADC rise to valid column data (0..15)
//
// Ports:
//   Clk          clock, rising edge
//   Reset        synchronous active-high reset
//   NRE_1/NRE_2  row 0 / row 1 read enables, active low
//   ADC          conversion strobe (level)
//   Col0_data    column 0 ADC result
//   Col1_data    column 1 ADC result
//   Data_out     FIFO head pixel (optionally tagged)
//   Data_valid   FIFO not empty
//   Data_ready   sink accepts Data_out when Data_valid is high
//   Frame_done   one-cycle pulse when a row 1 pair has been pushed
//   Frame_count  completed frames, wraps at 256
//   Row_err      one-cycle pulse on a rise with a bad row select
//   Overflow     sticky, set when a pair is dropped for lack of space
// ----------------------------------------------------------------------------
module pixel_readout #(
    parameter int W           = 8,
    parameter int DEPTH       = 8,
    parameter int ADC_LATENCY = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         NRE_1,
    input  logic         NRE_2,
    input  logic         ADC,
    input  logic [W-1:0] Col0_data,
    input  logic [W-1:0] Col1_data,
`ifdef PIXEL_READOUT_TAG_EN
    output logic [W+1:0] Data_out,
`else
    output logic [W-1:0] Data_out,
`endif
    output logic         Data_valid,
    input  logic         Data_ready,
    output logic         Frame_done,
    output logic [7:0]   Frame_count,
    output logic         Row_err,
    output logic         Overflow
);

`ifdef PIXEL_READOUT_TAG_EN
    localparam int DW = W + 2;
`else
    localparam int DW = W;
`endif
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PUSH0 = 2'd2,
        ST_PUSH1 = 2'd3
    } state_t;

    // Capture FSM state
    state_t         state_q, state_d;
    logic           adc_q, adc_prev_q;
    logic           row_q, row_d;
    logic [3:0]     lat_q, lat_d;
    logic [W-1:0]   col0_q, col0_d;
    logic [W-1:0]   col1_q, col1_d;

    // FIFO state
    logic [DW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    // Registered outputs
    logic [DW-1:0]  data_out_q, data_out_d;
    logic           data_valid_q, data_valid_d;
    logic           frame_done_q, frame_done_d;
    logic [7:0]     frame_count_q, frame_count_d;
    logic           row_err_q, row_err_d;
    logic           overflow_q, overflow_d;

    // Combinational helpers
    logic           rise_s;
    logic           row_ok_s;
    logic           push_s;
    logic           pop_s;
    logic [DW-1:0]  wdata_s;

    assign rise_s   = adc_q & ~adc_prev_q;
    // Exactly one enable low selects a row; NRE_1 high means row 1 is selected.
    assign row_ok_s = NRE_1 ^ NRE_2;
    assign pop_s    = data_valid_q & Data_ready;

    // Capture FSM next-state and FIFO write request
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        lat_d         = lat_q;
        col0_d        = col0_q;
        col1_d        = col1_q;
        push_s        = 1'b0;
        wdata_s       = {DW{1'b0}};
        row_err_d     = 1'b0;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        overflow_d    = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    if (row_ok_s) begin
                        row_d   = NRE_1;
                        lat_d   = 4'(ADC_LATENCY);
                        state_d = ST_WAIT;
                    end else begin
                        row_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_q == 4'd0) begin
                    col0_d = Col0_data;
                    col1_d = Col1_data;
                    // Both entries must fit now; later pops only add space.
                    if (count_q <= CW'(DEPTH - 2)) begin
                        state_d = ST_PUSH0;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            ST_PUSH0: begin
                push_s  = 1'b1;
`ifdef PIXEL_READOUT_TAG_EN
                wdata_s = {row_q, 1'b0, col0_q};
`else
                wdata_s = col0_q;
`endif
                state_d = ST_PUSH1;
            end
            ST_PUSH1: begin
                push_s  = 1'b1;
`ifdef PIXEL_READOUT_TAG_EN
                wdata_s = {row_q, 1'b1, col1_q};
`else
                wdata_s = col1_q;
`endif
                if (row_q) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                end else begin
                    frame_done_d  = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer/occupancy update and show-ahead head selection
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // The next head may be the entry being written this cycle (FIFO
        // becoming non-empty), so bypass the write data in that case.
        if (count_d == CW'(0)) begin
            data_out_d = data_out_q;
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            data_out_d = wdata_s;
        end else begin
            data_out_d = mem_q[rd_ptr_d];
        end
        data_valid_d = (count_d != CW'(0));
    end

    // State, counters, flags and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            adc_q         <= 1'b0;
            adc_prev_q    <= 1'b0;
            row_q         <= 1'b0;
            lat_q         <= 4'd0;
            col0_q        <= {W{1'b0}};
            col1_q        <= {W{1'b0}};
            wr_ptr_q      <= {PW{1'b0}};
            rd_ptr_q      <= {PW{1'b0}};
            count_q       <= {CW{1'b0}};
            data_out_q    <= {DW{1'b0}};
            data_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 8'd0;
            row_err_q     <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            adc_q         <= ADC;
            adc_prev_q    <= adc_q;
            row_q         <= row_d;
            lat_q         <= lat_d;
            col0_q        <= col0_d;
            col1_q        <= col1_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            row_err_q     <= row_err_d;
            overflow_q    <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge Clk) begin
        if (push_s && !Reset) begin
            mem_q[wr_ptr_q] <= wdata_s;
        end
    end

    assign Data_out    = data_out_q;
    assign Data_valid  = data_valid_q;
    assign Frame_done  = frame_done_q;
    assign Frame_count = frame_count_q;
    assign Row_err     = row_err_q;
    assign Overflow    = overflow_q;

endmodule

// File: tb/tb_pixel_readout.sv
// ----------------------------------------------------------------------------
// Testbench for pixel_readout. A transaction-level reference model keeps the
// expected FIFO contents as a queue of pixels stamped with the cycle they
// become visible, derived from the capture timing rules (WAIT entered two
// cycles after ADC is driven high, pushes land at +4+L and +5+L).
// ----------------------------------------------------------------------------
module tb_pixel_readout;

    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int L     = 2;
`ifdef PIXEL_READOUT_TAG_EN
    localparam int DW = W + 2;
`else
    localparam int DW = W;
`endif

    logic          Clk = 1'b0;
    logic          Reset;
    logic          NRE_1;
    logic          NRE_2;
    logic          ADC;
    logic [W-1:0]  Col0_data;
    logic [W-1:0]  Col1_data;
    logic [DW-1:0] Data_out;
    logic          Data_valid;
    logic          Data_ready;
    logic          Frame_done;
    logic [7:0]    Frame_count;
    logic          Row_err;
    logic          Overflow;

    pixel_readout #(.W(W), .DEPTH(DEPTH), .ADC_LATENCY(L)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .NRE_1      (NRE_1),
        .NRE_2      (NRE_2),
        .ADC        (ADC),
        .Col0_data  (Col0_data),
        .Col1_data  (Col1_data),
        .Data_out   (Data_out),
        .Data_valid (Data_valid),
        .Data_ready (Data_ready),
        .Frame_done (Frame_done),
        .Frame_count(Frame_count),
        .Row_err    (Row_err),
        .Overflow   (Overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [DW-1:0] d;
        int            vis;
    } ent_t;

    ent_t          mq[$];
    int            cyc;
    int            busy_until;
    int            pend_t;
    int            rerr_at;
    int            fdone_at;
    int            ovf_at;
    bit            pend;
    bit            pend_row;
    bit            m_adc;
    logic [W-1:0]  pend_c0;
    logic [W-1:0]  pend_c1;
    logic [DW-1:0] last_out;
    logic [DW-1:0] e_head;
    bit            e_valid;
    bit            e_fdone;
    bit            e_rerr;
    bit            e_ovf;
    logic [7:0]    e_count;
    int            errors;
    int            checks;

    function automatic logic [DW-1:0] mk(input logic row, input logic col, input logic [W-1:0] pix);
        logic [W+1:0] full;
        full = {row, col, pix};
`ifdef PIXEL_READOUT_TAG_EN
        return full;
`else
        return full[W-1:0];
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        pend       = 1'b0;
        busy_until = 0;
        rerr_at    = -1;
        fdone_at   = -1;
        ovf_at     = -1;
        last_out   = '0;
        e_head     = '0;
        e_valid    = 1'b0;
        e_fdone    = 1'b0;
        e_rerr     = 1'b0;
        e_ovf      = 1'b0;
        e_count    = 8'd0;
        m_adc      = 1'b0;
    endtask

    // Drive ADC and let the model note a rise that the idle FSM will act on.
    task automatic drive_adc(input bit v);
        if (v && !m_adc && (cyc + 1 >= busy_until)) begin
            if (NRE_1 ^ NRE_2) begin
                pend       = 1'b1;
                pend_t     = cyc;
                pend_row   = NRE_1;
                pend_c0    = Col0_data;
                pend_c1    = Col1_data;
                busy_until = cyc + 3 + L;
            end else begin
                rerr_at = cyc + 2;
            end
        end
        m_adc = v;
        ADC   = v;
    endtask

    task automatic launch(input bit row, input logic [W-1:0] c0, input logic [W-1:0] c1);
        NRE_1     = row;
        NRE_2     = ~row;
        Col0_data = c0;
        Col1_data = c1;
        drive_adc(1'b1);
    endtask

    // Advance one clock and update the model's expectations for the new cycle.
    task automatic step();
        bit pop;
        bit rst;
        pop = e_valid && Data_ready;
        rst = Reset;
        @(posedge Clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            if (pop) begin
                last_out = mq[0].d;
                void'(mq.pop_front());
            end
            if (pend && cyc == pend_t + 2 + L) begin
                pend = 1'b0;
                if (mq.size() <= DEPTH - 2) begin
                    mq.push_back('{d: mk(pend_row, 1'b0, pend_c0), vis: pend_t + 4 + L});
                    mq.push_back('{d: mk(pend_row, 1'b1, pend_c1), vis: pend_t + 5 + L});
                    busy_until = pend_t + 5 + L;
                    if (pend_row) fdone_at = pend_t + 5 + L;
                end else begin
                    ovf_at = pend_t + 3 + L;
                end
            end
            if (cyc == fdone_at) e_count = e_count + 8'd1;
            if (cyc == ovf_at) e_ovf = 1'b1;
            e_fdone = (cyc == fdone_at);
            e_rerr  = (cyc == rerr_at);
        end
        e_valid = (mq.size() > 0) && (mq[0].vis <= cyc);
        e_head  = e_valid ? mq[0].d : last_out;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) step();
        Reset = 1'b0;
        step();
        checks++; if (Data_out !== '0) begin errors++; $display("FAIL reset_data_out got=%h exp=0", Data_out); end
        checks++; if (Data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", Data_valid); end
        checks++; if (Frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", Frame_done); end
        checks++; if (Frame_count !== 8'd0) begin errors++; $display("FAIL reset_frame_count got=%0d exp=0", Frame_count); end
        checks++; if (Row_err !== 1'b0) begin errors++; $display("FAIL reset_row_err got=%b exp=0", Row_err); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", Overflow); end
    endtask

    task automatic test_single_row0();
        int t0;
        Data_ready = 1'b1;
        t0 = cyc;
        launch(1'b0, 8'h12, 8'h34);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 1) drive_adc(1'b0);
            checks++; if (Data_valid !== e_valid) begin errors++; $display("FAIL single_valid cyc=%0d got=%b exp=%b", cyc, Data_valid, e_valid); end
            checks++; if (Data_out !== e_head) begin errors++; $display("FAIL single_data cyc=%0d got=%h exp=%h", cyc, Data_out, e_head); end
            checks++; if (Frame_done !== 1'b0) begin errors++; $display("FAIL single_frame_done cyc=%0d got=%b exp=0", cyc, Frame_done); end
            if (cyc == t0 + 6) begin
                checks++; if (Data_valid !== 1'b1 || Data_out[W-1:0] !== 8'h12) begin errors++; $display("FAIL single_first valid=%b got=%h exp=12", Data_valid, Data_out[W-1:0]); end
            end
            if (cyc == t0 + 7) begin
                checks++; if (Data_valid !== 1'b1 || Data_out[W-1:0] !== 8'h34) begin errors++; $display("FAIL single_second valid=%b got=%h exp=34", Data_valid, Data_out[W-1:0]); end
            end
        end
    endtask

    task automatic test_two_rows();
        int fd_seen;
        fd_seen = 0;
        Data_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            if (r == 0) launch(1'b0, W'($urandom), W'($urandom));
            else        launch(1'b1, 8'h56, 8'h78);
            for (int i = 1; i <= 9; i++) begin
                step();
                if (i == 1) drive_adc(1'b0);
                if (Frame_done === 1'b1) fd_seen++;
                checks++; if (Data_valid !== e_valid) begin errors++; $display("FAIL rows_valid cyc=%0d got=%b exp=%b", cyc, Data_valid, e_valid); end
                checks++; if (Data_out !== e_head) begin errors++; $display("FAIL rows_data cyc=%0d got=%h exp=%h", cyc, Data_out, e_head); end
                checks++; if (Frame_done !== e_fdone) begin errors++; $display("FAIL rows_frame_done cyc=%0d got=%b exp=%b", cyc, Frame_done, e_fdone); end
            end
        end
        checks++; if (fd_seen !== 1) begin errors++; $display("FAIL rows_fd_pulses got=%0d exp=1", fd_seen); end
        checks++; if (Frame_count !== e_count) begin errors++; $display("FAIL rows_frame_count got=%0d exp=%0d", Frame_count, e_count); end
    endtask

    task automatic test_row_err();
        int seen;
        for (int k = 0; k < 2; k++) begin
            seen  = 0;
            NRE_1 = k[0];
            NRE_2 = k[0];
            drive_adc(1'b1);
            for (int i = 1; i <= 8; i++) begin
                step();
                if (i == 1) drive_adc(1'b0);
                if (Row_err === 1'b1) seen++;
                checks++; if (Row_err !== e_rerr) begin errors++; $display("FAIL rowerr_pulse k=%0d cyc=%0d got=%b exp=%b", k, cyc, Row_err, e_rerr); end
                checks++; if (Data_valid !== e_valid) begin errors++; $display("FAIL rowerr_valid k=%0d cyc=%0d got=%b exp=%b", k, cyc, Data_valid, e_valid); end
            end
            checks++; if (seen !== 1) begin errors++; $display("FAIL rowerr_count k=%0d got=%0d exp=1", k, seen); end
        end
    endtask

    task automatic test_overflow();
        int pops;
        pops = 0;
        Data_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            launch(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
            for (int i = 1; i <= 9; i++) begin
                step();
                if (i == 1) drive_adc(1'b0);
                checks++; if (Data_valid !== e_valid) begin errors++; $display("FAIL ovf_valid cyc=%0d got=%b exp=%b", cyc, Data_valid, e_valid); end
                checks++; if (Data_out !== e_head) begin errors++; $display("FAIL ovf_data cyc=%0d got=%h exp=%h", cyc, Data_out, e_head); end
                checks++; if (Overflow !== e_ovf) begin errors++; $display("FAIL ovf_flag cyc=%0d got=%b exp=%b", cyc, Overflow, e_ovf); end
                checks++; if (Frame_done !== e_fdone) begin errors++; $display("FAIL ovf_frame_done cyc=%0d got=%b exp=%b", cyc, Frame_done, e_fdone); end
            end
        end
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", Overflow); end
        for (int i = 0; i < 36; i++) begin
            Data_ready = (i < 24) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (Data_valid && Data_ready) pops++;
            step();
            checks++; if (Data_valid !== e_valid) begin errors++; $display("FAIL drain_valid cyc=%0d got=%b exp=%b", cyc, Data_valid, e_valid); end
            checks++; if (Data_out !== e_head) begin errors++; $display("FAIL drain_data cyc=%0d got=%h exp=%h", cyc, Data_out, e_head); end
        end
        checks++; if (pops !== DEPTH) begin errors++; $display("FAIL drain_pops got=%0d exp=%0d", pops, DEPTH); end
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", Overflow); end
        checks++; if (Frame_count !== e_count) begin errors++; $display("FAIL ovf_frame_count got=%0d exp=%0d", Frame_count, e_count); end
    endtask

    task automatic test_adc_hold();
        int pops;
        Data_ready = 1'b1;
        // Held high for ten cycles: a single rise.
        pops = 0;
        launch(1'b0, W'($urandom), W'($urandom));
        for (int i = 1; i <= 13; i++) begin
            if (Data_valid && Data_ready) pops++;
            step();
            if (i == 10) drive_adc(1'b0);
            checks++; if (Data_valid !== e_valid) begin errors++; $display("FAIL hold_valid cyc=%0d got=%b exp=%b", cyc, Data_valid, e_valid); end
            checks++; if (Data_out !== e_head) begin errors++; $display("FAIL hold_data cyc=%0d got=%h exp=%h", cyc, Data_out, e_head); end
        end
        checks++; if (pops !== 2) begin errors++; $display("FAIL hold_pairs got=%0d exp=2", pops); end
        // Second rise arrives while the FSM is in WAIT.
        pops = 0;
        launch(1'b1, W'($urandom), W'($urandom));
        for (int i = 1; i <= 12; i++) begin
            if (Data_valid && Data_ready) pops++;
            step();
            if (i == 1) drive_adc(1'b0);
            if (i == 2) drive_adc(1'b1);
            if (i == 3) drive_adc(1'b0);
            checks++; if (Data_valid !== e_valid) begin errors++; $display("FAIL rerise_valid cyc=%0d got=%b exp=%b", cyc, Data_valid, e_valid); end
            checks++; if (Data_out !== e_head) begin errors++; $display("FAIL rerise_data cyc=%0d got=%h exp=%h", cyc, Data_out, e_head); end
            checks++; if (Row_err !== 1'b0) begin errors++; $display("FAIL rerise_row_err cyc=%0d got=%b exp=0", cyc, Row_err); end
        end
        checks++; if (pops !== 2) begin errors++; $display("FAIL rerise_pairs got=%0d exp=2", pops); end
    endtask

    task automatic test_reset_abort();
        int t0;
        Data_ready = 1'b1;
        t0 = cyc;
        launch(1'b1, W'($urandom), W'($urandom));
        while (cyc < t0 + 3 + L) begin
            step();
            if (cyc == t0 + 1) drive_adc(1'b0);
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++; if (Data_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b exp=0", Data_valid); end
        checks++; if (Data_out !== '0) begin errors++; $display("FAIL abort_data got=%h exp=0", Data_out); end
        checks++; if (Frame_count !== 8'd0) begin errors++; $display("FAIL abort_frame_count got=%0d exp=0", Frame_count); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL abort_overflow got=%b exp=0", Overflow); end
        checks++; if (Frame_done !== 1'b0 || Row_err !== 1'b0) begin errors++; $display("FAIL abort_pulses got=%b%b exp=00", Frame_done, Row_err); end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (Data_valid !== e_valid) begin errors++; $display("FAIL abort_after_valid cyc=%0d got=%b exp=%b", cyc, Data_valid, e_valid); end
            checks++; if (Frame_done !== e_fdone) begin errors++; $display("FAIL abort_after_fd cyc=%0d got=%b exp=%b", cyc, Frame_done, e_fdone); end
        end
    endtask

    task automatic test_frame_wrap();
        int t0;
        int fd_seen;
        fd_seen = 0;
        Data_ready = 1'b1;
        for (int f = 0; f < 256; f++) begin
            t0 = cyc;
            launch(1'b1, W'($urandom), (f == 255) ? 8'hAB : W'($urandom));
            for (int i = 1; i <= 9; i++) begin
                step();
                if (i == 1) drive_adc(1'b0);
                if (Frame_done === 1'b1) fd_seen++;
                checks++; if (Frame_count !== e_count) begin errors++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", cyc, Frame_count, e_count); end
                checks++; if (Data_out !== e_head) begin errors++; $display("FAIL wrap_data cyc=%0d got=%h exp=%h", cyc, Data_out, e_head); end
                checks++; if (Frame_done !== e_fdone) begin errors++; $display("FAIL wrap_fd cyc=%0d got=%b exp=%b", cyc, Frame_done, e_fdone); end
`ifdef PIXEL_READOUT_TAG_EN
                if (f == 255 && cyc == t0 + 5 + L) begin
                    checks++; if (Data_out !== {1'b1, 1'b1, 8'hAB}) begin errors++; $display("FAIL tag_row1_col1 got=%h exp=%h", Data_out, {1'b1, 1'b1, 8'hAB}); end
                end
`endif
            end
        end
        checks++; if (fd_seen !== 256) begin errors++; $display("FAIL wrap_fd_pulses got=%0d exp=256", fd_seen); end
        checks++; if (Frame_count !== 8'd0) begin errors++; $display("FAIL wrap_zero got=%0d exp=0", Frame_count); end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        cyc        = 0;
        Reset      = 1'b1;
        ADC        = 1'b0;
        NRE_1      = 1'b1;
        NRE_2      = 1'b1;
        Col0_data  = '0;
        Col1_data  = '0;
        Data_ready = 1'b0;
        model_reset();
        test_reset();
        test_single_row0();
        test_two_rows();
        test_row_err();
        test_overflow();
        test_adc_hold();
        test_reset_abort();
        test_frame_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
